// File: rtl/fft_capture_pkg.sv
// Shared definitions for the FFT frame capture block: capture states,
// AHB register offsets and STATUS/CTRL bit positions.
package fft_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    // Byte offsets within the 13-bit AHB decode window
    localparam logic [12:0] CTRL_OFS    = 13'h000;
    localparam logic [12:0] STATUS_OFS  = 13'h004;
    localparam logic [12:0] COUNT_OFS   = 13'h008;
    localparam logic [12:0] SAMPLE_BASE = 13'h1000;

    localparam int CTRL_ARM_BIT   = 0;
    localparam int CTRL_ABORT_BIT = 1;

    localparam int STAT_SHORT_BIT    = 2;
    localparam int STAT_OVERFLOW_BIT = 3;
    localparam int STAT_RESYNC_BIT   = 4;

    function automatic logic [31:0] pack_status(input cap_state_t st,
                                                input logic short_f,
                                                input logic overflow_f,
                                                input logic resync_f);
        logic [31:0] w;
        w = '0;
        w[1:0] = st;
        w[STAT_SHORT_BIT]    = short_f;
        w[STAT_OVERFLOW_BIT] = overflow_f;
        w[STAT_RESYNC_BIT]   = resync_f;
        return w;
    endfunction

endpackage

// File: rtl/fft_capture_ram.sv
// Simple dual-port frame buffer: one synchronous write port (stream side)
// and one synchronous read port (AHB side), same clock.
module fft_capture_ram #(
    parameter int DW    = 16,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-before-write on a collision; the stream never needs same-cycle visibility
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/fft_frame_capture.sv
// AXI-Stream frame sink: captures one frame into RAM on software arm and
// exposes control, status, count and samples over a zero-wait AHB slave.
module fft_frame_capture
    import fft_capture_pkg::*;
#(
    parameter int DW       = 16,
    parameter int DATA_CNT = 1024,
    parameter int AW       = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] tdata_s,
    input  logic          tvalid_s,
    input  logic          tuser_s,
    input  logic          tlast_s,
    output logic          tready_s,
    input  logic [31:0]   haddr_s,
    input  logic [2:0]    hburst_s,
    input  logic [2:0]    hsize_s,
    input  logic [1:0]    htrans_s,
    input  logic [31:0]   hwdata_s,
    input  logic          hwrite_s,
    input  logic          hsel_s,
    output logic [31:0]   hrdata_s,
    output logic          hreadyout_s,
    output logic          hresp_s,
    output logic          frame_irq
);

    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DATA_CNT);
    localparam logic [AW:0] LAST_IDX = (AW+1)'(DATA_CNT - 1);

    cap_state_t  state_reg, state_next;
    logic [AW:0] count_reg, count_next;
    logic        short_reg, short_next;
    logic        overflow_reg, overflow_next;
    logic        resync_reg, resync_next;
    logic        irq_reg, irq_next;

    logic        ahb_valid_reg;
    logic        ahb_write_reg;
    logic [10:0] ahb_word_reg;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_rdata;

    logic        ctrl_wr, arm, abort, beat;
    logic [10:0] sample_idx;
    logic        sample_hit;
    logic        unused_bits;

    assign tready_s    = 1'b1;
    assign hreadyout_s = 1'b1;
    assign hresp_s     = 1'b0;
    assign frame_irq   = irq_reg;

    assign unused_bits = ^{hburst_s, hsize_s, htrans_s[0], hwdata_s[31:2],
                           haddr_s[31:13], haddr_s[1:0]};

    assign beat    = tvalid_s;
    assign ctrl_wr = ahb_valid_reg && ahb_write_reg && (ahb_word_reg == CTRL_OFS[12:2]);
    assign arm     = ctrl_wr && hwdata_s[CTRL_ARM_BIT];
    assign abort   = ctrl_wr && hwdata_s[CTRL_ABORT_BIT];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            short_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
            resync_reg    <= 1'b0;
            irq_reg       <= 1'b0;
            ahb_valid_reg <= 1'b0;
            ahb_write_reg <= 1'b0;
            ahb_word_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            short_reg     <= short_next;
            overflow_reg  <= overflow_next;
            resync_reg    <= resync_next;
            irq_reg       <= irq_next;
            ahb_valid_reg <= hsel_s && htrans_s[1];
            ahb_write_reg <= hwrite_s;
            ahb_word_reg  <= haddr_s[12:2];
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        short_next    = short_reg;
        overflow_next = overflow_reg;
        resync_next   = resync_reg;
        ram_we        = 1'b0;
        ram_waddr     = count_reg[AW-1:0];
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_next    = ST_ARMED;
                    count_next    = '0;
                    short_next    = 1'b0;
                    overflow_next = 1'b0;
                    resync_next   = 1'b0;
                end
            end
            ST_ARMED: begin
                if (beat && tuser_s) begin
                    ram_we     = 1'b1;
                    ram_waddr  = '0;
                    count_next = ONE_CNT;
                    if (tlast_s || DATA_CNT == 1) begin
                        state_next    = ST_DONE;
                        short_next    = tlast_s && (DATA_CNT > 1);
                        overflow_next = !tlast_s;
                    end else begin
                        state_next = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (beat) begin
                    ram_we = 1'b1;
                    if (tuser_s) begin
                        // A fresh start-of-frame discards the partial frame
                        ram_waddr   = '0;
                        count_next  = ONE_CNT;
                        resync_next = 1'b1;
                        if (tlast_s) begin
                            state_next = ST_DONE;
                            short_next = (DATA_CNT > 1);
                        end
                    end else begin
                        count_next = count_reg + ONE_CNT;
                        if (tlast_s) begin
                            state_next = ST_DONE;
                            short_next = (count_next < FULL_CNT);
                        end else if (count_reg == LAST_IDX) begin
                            state_next    = ST_DONE;
                            overflow_next = 1'b1;
                        end
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (abort) begin
            state_next = ST_IDLE;
        end
    end

    assign irq_next = (state_next == ST_DONE) && (state_reg != ST_DONE);

    assign sample_idx = ahb_word_reg - SAMPLE_BASE[12:2];
    assign sample_hit = (ahb_word_reg >= SAMPLE_BASE[12:2]) && (32'(sample_idx) < 32'(DATA_CNT));

    always_comb begin
        hrdata_s = '0;
        if (ahb_valid_reg && !ahb_write_reg) begin
            if (ahb_word_reg == STATUS_OFS[12:2]) begin
                hrdata_s = pack_status(state_reg, short_reg, overflow_reg, resync_reg);
            end else if (ahb_word_reg == COUNT_OFS[12:2]) begin
                hrdata_s = 32'(count_reg);
            end else if (sample_hit) begin
                hrdata_s = 32'($signed(ram_rdata));
            end
        end
    end

    // Read address comes straight from the address phase so data lands in the data phase
    fft_capture_ram #(
        .DW    (DW),
        .DEPTH (DATA_CNT),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (tdata_s),
        .raddr (haddr_s[AW+1:2]),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_fft_frame_capture.sv
// Bench for fft_frame_capture: stream frames in, read registers and samples
// back over AHB with a pipelined read scoreboard.
module tb_fft_frame_capture;

    localparam int DW       = 16;
    localparam int DATA_CNT = 1024;
    localparam int AW       = 10;

    localparam logic [12:0] A_CTRL   = 13'h000;
    localparam logic [12:0] A_STATUS = 13'h004;
    localparam logic [12:0] A_COUNT  = 13'h008;
    localparam logic [12:0] A_UNMAP  = 13'h00C;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] tdata_s;
    logic          tvalid_s, tuser_s, tlast_s, tready_s;
    logic [31:0]   haddr_s, hwdata_s, hrdata_s;
    logic [2:0]    hburst_s, hsize_s;
    logic [1:0]    htrans_s;
    logic          hwrite_s, hsel_s, hreadyout_s, hresp_s, frame_irq;

    typedef struct {
        logic [12:0] addr;
        logic [31:0] data;
    } rd_vec_t;

    rd_vec_t tbl[$];
    rd_vec_t exp_q[$];
    rd_vec_t frame_tbl[7];

    int   total = 0;
    int   bad = 0;
    int   irq_cnt = 0;
    int   irq_long = 0;
    int   sticky = 0;
    int   irq0;
    logic irq_prev = 1'b0;

    fft_frame_capture #(.DW(DW), .DATA_CNT(DATA_CNT), .AW(AW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tdata_s     (tdata_s),
        .tvalid_s    (tvalid_s),
        .tuser_s     (tuser_s),
        .tlast_s     (tlast_s),
        .tready_s    (tready_s),
        .haddr_s     (haddr_s),
        .hburst_s    (hburst_s),
        .hsize_s     (hsize_s),
        .htrans_s    (htrans_s),
        .hwdata_s    (hwdata_s),
        .hwrite_s    (hwrite_s),
        .hsel_s      (hsel_s),
        .hrdata_s    (hrdata_s),
        .hreadyout_s (hreadyout_s),
        .hresp_s     (hresp_s),
        .frame_irq   (frame_irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_irq) irq_cnt++;
        if (frame_irq && irq_prev) irq_long++;
        irq_prev = frame_irq;
        if (reset_n && (hreadyout_s !== 1'b1 || hresp_s !== 1'b0 || tready_s !== 1'b1)) sticky++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    function automatic logic [12:0] smp(input int i);
        return 13'(32'h1000 + 4 * i);
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", nm, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", nm, got);
        end
    endtask

    task automatic add(input logic [12:0] a, input logic [31:0] d);
        rd_vec_t v;
        v.addr = a;
        v.data = d;
        tbl.push_back(v);
    endtask

    // Back-to-back reads: address phase k overlaps data phase k-1
    task automatic run_reads();
        int n;
        rd_vec_t e;
        n = tbl.size();
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            if (k > 0) begin
                e = exp_q.pop_front();
                check($sformatf("rd[%04h]", e.addr), hrdata_s, e.data);
            end
            if (k < n) begin
                haddr_s  = {19'd0, tbl[k].addr};
                hwrite_s = 1'b0;
                hsel_s   = 1'b1;
                htrans_s = 2'b10;
                exp_q.push_back(tbl[k]);
            end else begin
                hsel_s   = 1'b0;
                htrans_s = 2'b00;
            end
        end
        tbl.delete();
    endtask

    task automatic ahb_write(input logic [12:0] a, input logic [31:0] d);
        @(negedge clk);
        haddr_s  = {19'd0, a};
        hwrite_s = 1'b1;
        hsel_s   = 1'b1;
        htrans_s = 2'b10;
        @(negedge clk);
        hwdata_s = d;
        hwrite_s = 1'b0;
        hsel_s   = 1'b0;
        htrans_s = 2'b00;
        $display("wr   [%04h] <= 0x%08h", a, d);
    endtask

    task automatic beat(input logic [15:0] d, input logic u, input logic l);
        @(negedge clk);
        tvalid_s = 1'b1;
        tdata_s  = d;
        tuser_s  = u;
        tlast_s  = l;
    endtask

    task automatic stream_idle();
        @(negedge clk);
        tvalid_s = 1'b0;
        tuser_s  = 1'b0;
        tlast_s  = 1'b0;
    endtask

    initial begin
        frame_tbl[0] = '{A_STATUS, 32'h3};
        frame_tbl[1] = '{A_COUNT, 32'd1024};
        frame_tbl[2] = '{smp(5), 32'd5};
        frame_tbl[3] = '{smp(1023), 32'd1023};
        frame_tbl[4] = '{smp(0), 32'd0};
        frame_tbl[5] = '{A_UNMAP, 32'd0};
        frame_tbl[6] = '{A_CTRL, 32'd0};

        reset_n  = 1'b0;
        tdata_s  = '0;
        tvalid_s = 1'b0;
        tuser_s  = 1'b0;
        tlast_s  = 1'b0;
        haddr_s  = '0;
        hwdata_s = '0;
        hburst_s = '0;
        hsize_s  = 3'b010;
        htrans_s = '0;
        hwrite_s = 1'b0;
        hsel_s   = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_hrdata", hrdata_s, 32'd0);
        check("rst_irq", {31'd0, frame_irq}, 32'd0);
        check("rst_tready", {31'd0, tready_s}, 32'd1);
        add(A_STATUS, 32'd0);
        add(A_COUNT, 32'd0);
        run_reads();

        // Full 1024-sample frame
        ahb_write(A_CTRL, 32'd1);
        add(A_STATUS, 32'd1);
        run_reads();
        irq0 = irq_cnt;
        for (int i = 0; i < 1024; i++) beat(16'(i), i == 0, i == 1023);
        stream_idle();
        foreach (frame_tbl[i]) add(frame_tbl[i].addr, frame_tbl[i].data);
        run_reads();
        check("full_irq", 32'(irq_cnt - irq0), 32'd1);

        // Leading beats without SOF dropped, short frame
        ahb_write(A_CTRL, 32'd1);
        add(A_COUNT, 32'd0);
        add(A_STATUS, 32'd1);
        run_reads();
        irq0 = irq_cnt;
        for (int i = 0; i < 3; i++) beat(16'(16'h1110 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) beat(16'(16'h50 + i), i == 0, i == 9);
        stream_idle();
        add(A_STATUS, 32'h7);
        add(A_COUNT, 32'd10);
        add(smp(0), 32'h50);
        add(smp(9), 32'h59);
        run_reads();
        check("short_irq", 32'(irq_cnt - irq0), 32'd1);

        // Overflow: no tlast, extra beats dropped
        ahb_write(A_CTRL, 32'd1);
        irq0 = irq_cnt;
        for (int i = 0; i < 1100; i++) beat(16'(i + 7), i == 0, 1'b0);
        stream_idle();
        add(A_STATUS, 32'hB);
        add(A_COUNT, 32'd1024);
        add(smp(0), 32'd7);
        add(smp(512), 32'd519);
        add(smp(1023), 32'd1030);
        run_reads();
        check("ovf_irq", 32'(irq_cnt - irq0), 32'd1);

        // Resync on a second SOF mid-frame
        ahb_write(A_CTRL, 32'd1);
        irq0 = irq_cnt;
        for (int i = 0; i < 8; i++) beat(16'(16'hA0 + i), i == 0 || i == 4, i == 7);
        stream_idle();
        add(A_STATUS, 32'h17);
        add(A_COUNT, 32'd4);
        add(smp(0), 32'hA4);
        add(smp(3), 32'hA7);
        run_reads();
        check("resync_irq", 32'(irq_cnt - irq0), 32'd1);
        ahb_write(A_CTRL, 32'd2);
        add(A_STATUS, 32'h14);
        add(A_COUNT, 32'd4);
        run_reads();

        // Abort mid-capture; ARM during CAPTURE ignored
        ahb_write(A_CTRL, 32'd1);
        irq0 = irq_cnt;
        for (int i = 0; i < 5; i++) beat(16'(16'h300 + i), i == 0, 1'b0);
        stream_idle();
        add(A_STATUS, 32'h2);
        add(A_COUNT, 32'd5);
        add(smp(2), 32'h302);
        run_reads();
        ahb_write(A_CTRL, 32'd1);
        add(A_STATUS, 32'h2);
        run_reads();
        ahb_write(A_CTRL, 32'd3);
        for (int i = 0; i < 4; i++) beat(16'(16'h400 + i), i == 0, i == 3);
        stream_idle();
        add(A_STATUS, 32'h0);
        add(A_COUNT, 32'd5);
        add(smp(0), 32'h300);
        run_reads();
        check("abort_irq", 32'(irq_cnt - irq0), 32'd0);
        ahb_write(A_CTRL, 32'd1);
        add(A_STATUS, 32'h1);
        add(A_COUNT, 32'd0);
        run_reads();

        // Sign extension; beats in DONE dropped
        beat(16'h8000, 1'b1, 1'b0);
        beat(16'h7FFF, 1'b0, 1'b1);
        beat(16'h1234, 1'b1, 1'b0);
        stream_idle();
        add(A_STATUS, 32'h7);
        add(A_COUNT, 32'd2);
        add(smp(0), 32'hFFFF8000);
        add(smp(1), 32'h00007FFF);
        add(A_UNMAP, 32'd0);
        run_reads();

        // Reset mid-capture
        ahb_write(A_CTRL, 32'd1);
        for (int i = 0; i < 3; i++) beat(16'(i), i == 0, 1'b0);
        stream_idle();
        irq0 = irq_cnt;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        add(A_STATUS, 32'h0);
        add(A_COUNT, 32'd0);
        run_reads();
        check("rst_mid_irq", 32'(irq_cnt - irq0), 32'd0);

        check("irq_one_cycle", 32'(irq_long), 32'd0);
        check("bus_constants", 32'(sticky), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
